// File: rtl/mig_addr_remap_slice_pkg.sv
// Shared definitions for the DSID address-remap slice: miss policy encodings
// and the bit layout of the cfg_rdata readback word.
package mig_addr_remap_slice_pkg;

    typedef enum int {
        MISS_ZERO = 0,
        MISS_PASS = 1
    } miss_mode_e;

    localparam int CNT_WIDTH = 32;

    // cfg_rdata layout, LSB first: base, mask, dsid, valid
    function automatic int rd_base_lsb();
        return 0;
    endfunction

    function automatic int rd_mask_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int rd_dsid_lsb(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int rd_valid_bit(input int dsid_w, input int addr_w);
        return 2 * addr_w + dsid_w;
    endfunction

    function automatic int rd_width(input int dsid_w, input int addr_w);
        return 2 * addr_w + dsid_w + 1;
    endfunction

endpackage

// File: rtl/mig_remap_chan.sv
// One address channel: table lookup, translate, one-deep registered slice
// and saturating miss counter.
module mig_remap_chan
    import mig_addr_remap_slice_pkg::*;
#(
    parameter int DSID_W      = 16,
    parameter int ADDR_W      = 32,
    parameter int NUM_ENTRIES = 4,
    parameter int SIDE_W      = 32,
    parameter int MISS_MODE   = MISS_ZERO
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NUM_ENTRIES-1:0]                tbl_valid,
    input  logic [NUM_ENTRIES-1:0][DSID_W-1:0]    tbl_dsid,
    input  logic [NUM_ENTRIES-1:0][ADDR_W-1:0]    tbl_base,
    input  logic [NUM_ENTRIES-1:0][ADDR_W-1:0]    tbl_mask,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [ADDR_W-1:0]                     s_addr,
    input  logic [DSID_W-1:0]                     s_user,
    input  logic [SIDE_W-1:0]                     s_side,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [ADDR_W-1:0]                     m_addr,
    output logic [DSID_W-1:0]                     m_user,
    output logic [SIDE_W-1:0]                     m_side,
    input  logic                                  clr_cnt,
    output logic [CNT_WIDTH-1:0]                  miss_cnt
);

    logic                 hit;
    logic [ADDR_W-1:0]    sel_base;
    logic [ADDR_W-1:0]    sel_mask;
    logic [ADDR_W-1:0]    xlat_addr;
    logic                 full;
    logic                 rdy_q;
    logic                 accept;
    logic [CNT_WIDTH-1:0] cnt_q;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        sel_base = '0;
        sel_mask = '0;
        // Scan high to low so the lowest matching index is the one left standing
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (tbl_valid[i] && (tbl_dsid[i] == s_user)) begin
                hit      = 1'b1;
                sel_base = tbl_base[i];
                sel_mask = tbl_mask[i];
            end
        end
    end

    always_comb begin
        if (hit) begin
            xlat_addr = (s_addr & ~sel_mask) | sel_base;
        end else if (MISS_MODE == MISS_PASS) begin
            xlat_addr = s_addr;
        end else begin
            xlat_addr = '0;
        end
    end

    assign s_ready = rdy_q && (!full || m_ready);
    assign accept  = s_valid && s_ready;
    assign m_valid = full;

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values and simulation matches hardware.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            full   <= 1'b0;
            m_addr <= '0;
            m_user <= '0;
            m_side <= '0;
        end else if (accept) begin
            full   <= 1'b1;
            m_addr <= xlat_addr;
            m_user <= s_user;
            m_side <= s_side;
        end else if (m_ready) begin
            full   <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (accept && !hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign miss_cnt = cnt_q;

endmodule

// File: rtl/mig_addr_remap_slice.sv
// DSID-tagged address remap between the AXI master side and the MIG: owns the
// associative table and drives one remap channel each for AW and AR.
module mig_addr_remap_slice
    import mig_addr_remap_slice_pkg::*;
#(
    parameter int C_DSID_WIDTH  = 16,
    parameter int C_ADDR_WIDTH  = 32,
    parameter int C_NUM_ENTRIES = 4,
    parameter int C_IDX_WIDTH   = 2,
    parameter int C_SIDE_WIDTH  = 32,
    parameter int C_MISS_MODE   = MISS_ZERO
) (
    input  logic                                          aclk,
    input  logic                                          aresetn,
    input  logic                                          cfg_wr_en,
    input  logic [C_IDX_WIDTH-1:0]                        cfg_idx,
    input  logic                                          cfg_valid,
    input  logic [C_DSID_WIDTH-1:0]                       cfg_dsid,
    input  logic [C_ADDR_WIDTH-1:0]                       cfg_base,
    input  logic [C_ADDR_WIDTH-1:0]                       cfg_mask,
    output logic [rd_width(C_DSID_WIDTH,C_ADDR_WIDTH)-1:0] cfg_rdata,
    input  logic                                          s_aw_valid,
    output logic                                          s_aw_ready,
    input  logic [C_ADDR_WIDTH-1:0]                       s_aw_addr,
    input  logic [C_DSID_WIDTH-1:0]                       s_aw_user,
    input  logic [C_SIDE_WIDTH-1:0]                       s_aw_side,
    output logic                                          m_aw_valid,
    input  logic                                          m_aw_ready,
    output logic [C_ADDR_WIDTH-1:0]                       m_aw_addr,
    output logic [C_DSID_WIDTH-1:0]                       m_aw_user,
    output logic [C_SIDE_WIDTH-1:0]                       m_aw_side,
    input  logic                                          s_ar_valid,
    output logic                                          s_ar_ready,
    input  logic [C_ADDR_WIDTH-1:0]                       s_ar_addr,
    input  logic [C_DSID_WIDTH-1:0]                       s_ar_user,
    input  logic [C_SIDE_WIDTH-1:0]                       s_ar_side,
    output logic                                          m_ar_valid,
    input  logic                                          m_ar_ready,
    output logic [C_ADDR_WIDTH-1:0]                       m_ar_addr,
    output logic [C_DSID_WIDTH-1:0]                       m_ar_user,
    output logic [C_SIDE_WIDTH-1:0]                       m_ar_side,
    output logic [CNT_WIDTH-1:0]                          aw_miss_cnt,
    output logic [CNT_WIDTH-1:0]                          ar_miss_cnt,
    input  logic                                          clr_cnt
);

    localparam int MASK_LSB  = rd_mask_lsb(C_ADDR_WIDTH);
    localparam int DSID_LSB  = rd_dsid_lsb(C_ADDR_WIDTH);
    localparam int VALID_BIT = rd_valid_bit(C_DSID_WIDTH, C_ADDR_WIDTH);

    logic [C_NUM_ENTRIES-1:0]                   tbl_valid;
    logic [C_NUM_ENTRIES-1:0][C_DSID_WIDTH-1:0] tbl_dsid;
    logic [C_NUM_ENTRIES-1:0][C_ADDR_WIDTH-1:0] tbl_base;
    logic [C_NUM_ENTRIES-1:0][C_ADDR_WIDTH-1:0] tbl_mask;
    logic                                       idx_ok;

    assign idx_ok = int'(cfg_idx) < C_NUM_ENTRIES;

    // NOTE: the table is a handful of flops and its valid bits must be clear out of reset, so the whole array is reset rather than left as RAM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tbl_valid <= '0;
            tbl_dsid  <= '0;
            tbl_base  <= '0;
            tbl_mask  <= '0;
        end else if (cfg_wr_en && idx_ok) begin
            tbl_valid[cfg_idx] <= cfg_valid;
            tbl_dsid[cfg_idx]  <= cfg_dsid;
            tbl_base[cfg_idx]  <= cfg_base;
            tbl_mask[cfg_idx]  <= cfg_mask;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        if (idx_ok) begin
            cfg_rdata[rd_base_lsb() +: C_ADDR_WIDTH] = tbl_base[cfg_idx];
            cfg_rdata[MASK_LSB +: C_ADDR_WIDTH]      = tbl_mask[cfg_idx];
            cfg_rdata[DSID_LSB +: C_DSID_WIDTH]      = tbl_dsid[cfg_idx];
            cfg_rdata[VALID_BIT]                     = tbl_valid[cfg_idx];
        end
    end

    mig_remap_chan #(
        .DSID_W      (C_DSID_WIDTH),
        .ADDR_W      (C_ADDR_WIDTH),
        .NUM_ENTRIES (C_NUM_ENTRIES),
        .SIDE_W      (C_SIDE_WIDTH),
        .MISS_MODE   (C_MISS_MODE)
    ) u_aw (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .tbl_valid (tbl_valid),
        .tbl_dsid  (tbl_dsid),
        .tbl_base  (tbl_base),
        .tbl_mask  (tbl_mask),
        .s_valid   (s_aw_valid),
        .s_ready   (s_aw_ready),
        .s_addr    (s_aw_addr),
        .s_user    (s_aw_user),
        .s_side    (s_aw_side),
        .m_valid   (m_aw_valid),
        .m_ready   (m_aw_ready),
        .m_addr    (m_aw_addr),
        .m_user    (m_aw_user),
        .m_side    (m_aw_side),
        .clr_cnt   (clr_cnt),
        .miss_cnt  (aw_miss_cnt)
    );

    mig_remap_chan #(
        .DSID_W      (C_DSID_WIDTH),
        .ADDR_W      (C_ADDR_WIDTH),
        .NUM_ENTRIES (C_NUM_ENTRIES),
        .SIDE_W      (C_SIDE_WIDTH),
        .MISS_MODE   (C_MISS_MODE)
    ) u_ar (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .tbl_valid (tbl_valid),
        .tbl_dsid  (tbl_dsid),
        .tbl_base  (tbl_base),
        .tbl_mask  (tbl_mask),
        .s_valid   (s_ar_valid),
        .s_ready   (s_ar_ready),
        .s_addr    (s_ar_addr),
        .s_user    (s_ar_user),
        .s_side    (s_ar_side),
        .m_valid   (m_ar_valid),
        .m_ready   (m_ar_ready),
        .m_addr    (m_ar_addr),
        .m_user    (m_ar_user),
        .m_side    (m_ar_side),
        .clr_cnt   (clr_cnt),
        .miss_cnt  (ar_miss_cnt)
    );

endmodule

// File: tb/tb_mig_addr_remap_slice.sv
// Bench for mig_addr_remap_slice: a zero-on-miss and a pass-on-miss instance
// share stimulus and are compared every cycle against a queue-based model.
module tb_mig_addr_remap_slice;

    localparam int RD_W = 81;

    typedef struct packed {
        logic [31:0] a0;
        logic [31:0] a1;
        logic [15:0] user;
        logic [31:0] side;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cfg_wr_en, cfg_valid, clr_cnt;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_dsid;
    logic [31:0] cfg_base, cfg_mask;
    logic        s_aw_valid, m_aw_ready, s_ar_valid, m_ar_ready;
    logic [31:0] s_aw_addr, s_aw_side, s_ar_addr, s_ar_side;
    logic [15:0] s_aw_user, s_ar_user;

    logic [RD_W-1:0] cfg_rdata, cfg_rdata_p;
    logic        s_aw_ready, m_aw_valid, s_ar_ready, m_ar_valid;
    logic [31:0] m_aw_addr, m_aw_side, m_ar_addr, m_ar_side, aw_miss_cnt, ar_miss_cnt;
    logic [15:0] m_aw_user, m_ar_user;
    logic        s_aw_ready_p, m_aw_valid_p, s_ar_ready_p, m_ar_valid_p;
    logic [31:0] m_aw_addr_p, m_aw_side_p, m_ar_addr_p, m_ar_side_p, aw_miss_cnt_p, ar_miss_cnt_p;
    logic [15:0] m_aw_user_p, m_ar_user_p;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    mig_addr_remap_slice #(.C_MISS_MODE(0)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_dsid(cfg_dsid),
        .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_rdata(cfg_rdata),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_aw_user(s_aw_user), .s_aw_side(s_aw_side),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
        .m_aw_user(m_aw_user), .m_aw_side(m_aw_side),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_user(s_ar_user), .s_ar_side(s_ar_side),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_user(m_ar_user), .m_ar_side(m_ar_side),
        .aw_miss_cnt(aw_miss_cnt), .ar_miss_cnt(ar_miss_cnt), .clr_cnt(clr_cnt)
    );

    mig_addr_remap_slice #(.C_MISS_MODE(1)) dut_pass (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_dsid(cfg_dsid),
        .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_rdata(cfg_rdata_p),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready_p), .s_aw_addr(s_aw_addr),
        .s_aw_user(s_aw_user), .s_aw_side(s_aw_side),
        .m_aw_valid(m_aw_valid_p), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr_p),
        .m_aw_user(m_aw_user_p), .m_aw_side(m_aw_side_p),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready_p), .s_ar_addr(s_ar_addr),
        .s_ar_user(s_ar_user), .s_ar_side(s_ar_side),
        .m_ar_valid(m_ar_valid_p), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr_p),
        .m_ar_user(m_ar_user_p), .m_ar_side(m_ar_side_p),
        .aw_miss_cnt(aw_miss_cnt_p), .ar_miss_cnt(ar_miss_cnt_p), .clr_cnt(clr_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_v [4];
    logic [15:0] m_d [4];
    logic [31:0] m_b [4];
    logic [31:0] m_m [4];
    beat_t       q_aw[$];
    beat_t       q_ar[$];
    logic [31:0] exp_cnt [4];   // aw, ar (zero instance), aw, ar (pass instance)
    bit          started;
    bit          aw_acc, ar_acc, aw_miss, ar_miss;
    beat_t       aw_beat, ar_beat;

    function automatic beat_t model_beat(input logic [31:0] a, input logic [15:0] u,
                                         input logic [31:0] s, output bit miss);
        beat_t b;
        b.user = u;
        b.side = s;
        b.a0   = 32'h0;
        b.a1   = a;
        miss   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (m_v[i] && m_d[i] == u) begin
                b.a0 = (a & ~m_m[i]) | m_b[i];
                b.a1 = b.a0;
                miss = 1'b0;
                break;
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q_aw.delete();
            q_ar.delete();
            for (int i = 0; i < 4; i++) begin
                m_v[i] = 1'b0; m_d[i] = '0; m_b[i] = '0; m_m[i] = '0; exp_cnt[i] = '0;
            end
            started = 1'b0;
        end else begin
            aw_acc = s_aw_valid && started && (q_aw.size() == 0 || m_aw_ready);
            ar_acc = s_ar_valid && started && (q_ar.size() == 0 || m_ar_ready);
            aw_beat = model_beat(s_aw_addr, s_aw_user, s_aw_side, aw_miss);
            ar_beat = model_beat(s_ar_addr, s_ar_user, s_ar_side, ar_miss);
            if (q_aw.size() > 0 && m_aw_ready) void'(q_aw.pop_front());
            if (q_ar.size() > 0 && m_ar_ready) void'(q_ar.pop_front());
            if (aw_acc) q_aw.push_back(aw_beat);
            if (ar_acc) q_ar.push_back(ar_beat);
            if (clr_cnt) begin
                for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
            end else begin
                if (aw_acc && aw_miss) begin
                    exp_cnt[0] = sat_inc(exp_cnt[0]);
                    exp_cnt[2] = sat_inc(exp_cnt[2]);
                end
                if (ar_acc && ar_miss) begin
                    exp_cnt[1] = sat_inc(exp_cnt[1]);
                    exp_cnt[3] = sat_inc(exp_cnt[3]);
                end
            end
            if (cfg_wr_en) begin
                m_v[cfg_idx] = cfg_valid;
                m_d[cfg_idx] = cfg_dsid;
                m_b[cfg_idx] = cfg_base;
                m_m[cfg_idx] = cfg_mask;
            end
            started = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge aclk) begin
        logic exp_aw_rdy, exp_ar_rdy;
        logic [RD_W-1:0] exp_rd;
        exp_aw_rdy = started && (q_aw.size() == 0 || m_aw_ready);
        exp_ar_rdy = started && (q_ar.size() == 0 || m_ar_ready);
        exp_rd = {m_v[cfg_idx], m_d[cfg_idx], m_m[cfg_idx], m_b[cfg_idx]};
        check("s_aw_ready", s_aw_ready, exp_aw_rdy);
        check("s_ar_ready", s_ar_ready, exp_ar_rdy);
        check("s_aw_ready_p", s_aw_ready_p, exp_aw_rdy);
        check("s_ar_ready_p", s_ar_ready_p, exp_ar_rdy);
        check("m_aw_valid", m_aw_valid, q_aw.size() > 0);
        check("m_ar_valid", m_ar_valid, q_ar.size() > 0);
        check("m_aw_valid_p", m_aw_valid_p, q_aw.size() > 0);
        check("m_ar_valid_p", m_ar_valid_p, q_ar.size() > 0);
        if (q_aw.size() > 0) begin
            check("m_aw_addr", m_aw_addr, q_aw[0].a0);
            check("m_aw_addr_p", m_aw_addr_p, q_aw[0].a1);
            check("m_aw_user", m_aw_user, q_aw[0].user);
            check("m_aw_side", m_aw_side, q_aw[0].side);
            check("m_aw_side_p", m_aw_side_p, q_aw[0].side);
        end
        if (q_ar.size() > 0) begin
            check("m_ar_addr", m_ar_addr, q_ar[0].a0);
            check("m_ar_addr_p", m_ar_addr_p, q_ar[0].a1);
            check("m_ar_user", m_ar_user, q_ar[0].user);
            check("m_ar_side", m_ar_side, q_ar[0].side);
            check("m_ar_user_p", m_ar_user_p, q_ar[0].user);
        end
        check("aw_miss_cnt", aw_miss_cnt, exp_cnt[0]);
        check("ar_miss_cnt", ar_miss_cnt, exp_cnt[1]);
        check("aw_miss_cnt_p", aw_miss_cnt_p, exp_cnt[2]);
        check("ar_miss_cnt_p", ar_miss_cnt_p, exp_cnt[3]);
        check("cfg_rdata", cfg_rdata, exp_rd);
        check("cfg_rdata_p", cfg_rdata_p, exp_rd);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        cfg_wr_en = 0; cfg_idx = 0; cfg_valid = 0; cfg_dsid = 0; cfg_base = 0; cfg_mask = 0;
        s_aw_valid = 0; s_aw_addr = 0; s_aw_user = 0; s_aw_side = 0; m_aw_ready = 1;
        s_ar_valid = 0; s_ar_addr = 0; s_ar_user = 0; s_ar_side = 0; m_ar_ready = 1;
        clr_cnt = 0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic v, input logic [15:0] d,
                             input logic [31:0] b, input logic [31:0] m);
        cfg_wr_en = 1; cfg_idx = idx; cfg_valid = v; cfg_dsid = d; cfg_base = b; cfg_mask = m;
    endtask

    initial begin
        int sent, n_out, first, last;
        bit acc;

        aresetn = 1'b0;
        idle();
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_aw_valid", m_aw_valid, 1'b0);
        check("rst_m_aw_addr", m_aw_addr, 32'h0);
        check("rst_aw_miss_cnt", aw_miss_cnt, 32'h0);
        aresetn = 1'b1;
        step();
        step();
        check("ready_after_rst", s_aw_ready, 1'b1);

        // entry 0 hit
        cfg_write(2'd0, 1'b1, 16'h0001, 32'h4000_0000, 32'hC000_0000);
        step();
        cfg_wr_en = 0;
        s_aw_valid = 1; s_aw_addr = 32'h1234_5678; s_aw_user = 16'h0001; s_aw_side = 32'hDEAD_BEEF;
        step();
        s_aw_valid = 0;
        @(negedge aclk);
        check("hit_addr", m_aw_addr, 32'h5234_5678);
        check("hit_side", m_aw_side, 32'hDEAD_BEEF);
        check("hit_cnt", aw_miss_cnt, 32'h0);
        step();

        // lowest index wins
        cfg_write(2'd1, 1'b1, 16'h0002, 32'h1000_0000, 32'hF000_0000);
        step();
        cfg_write(2'd2, 1'b1, 16'h0002, 32'h2000_0000, 32'hF000_0000);
        step();
        cfg_wr_en = 0;
        s_ar_valid = 1; s_ar_addr = 32'h0000_0100; s_ar_user = 16'h0002; s_ar_side = 32'h1;
        step();
        s_ar_valid = 0;
        @(negedge aclk);
        check("lowest_idx", m_ar_addr, 32'h1000_0100);
        step();

        // miss, both policies
        s_aw_valid = 1; s_aw_addr = 32'h8765_4321; s_aw_user = 16'h0007; s_aw_side = 32'h7;
        step();
        s_aw_valid = 0;
        @(negedge aclk);
        check("miss_zero", m_aw_addr, 32'h0);
        check("miss_pass", m_aw_addr_p, 32'h8765_4321);
        check("miss_cnt1", aw_miss_cnt, 32'd1);
        check("miss_cnt1_p", aw_miss_cnt_p, 32'd1);
        step();

        // stall then stream 8 beats
        sent = 0; n_out = 0; first = -1; last = -1;
        for (int c = 0; c < 30; c++) begin
            m_ar_ready = (c >= 5);
            s_ar_valid = (sent < 8);
            s_ar_addr  = 32'h0000_0100 + 32'(sent * 16);
            s_ar_user  = 16'h0002;
            s_ar_side  = 32'hA5A5_0000 | 32'(sent);
            @(negedge aclk);
            if (c == 3) begin
                check("stall_ready", s_ar_ready, 1'b0);
                check("stall_addr", m_ar_addr, 32'h1000_0100);
                check("stall_side", m_ar_side, 32'hA5A5_0000);
            end
            acc = s_ar_valid && s_ar_ready;
            if (m_ar_valid && m_ar_ready) begin
                if (first < 0) first = c;
                last = c;
                n_out++;
            end
            step();
            if (acc) sent++;
        end
        s_ar_valid = 0; m_ar_ready = 1;
        check("stream_count", n_out, 8);
        check("stream_span", last - first, 7);

        // write-through-lookup collision uses old contents
        cfg_write(2'd0, 1'b0, 16'h0001, 32'h4000_0000, 32'hC000_0000);
        s_aw_valid = 1; s_aw_addr = 32'h1234_5678; s_aw_user = 16'h0001; s_aw_side = 32'h55;
        step();
        cfg_wr_en = 0;
        @(negedge aclk);
        check("old_entry_hit", m_aw_addr, 32'h5234_5678);
        step();
        s_aw_valid = 0;
        @(negedge aclk);
        check("new_entry_miss", m_aw_addr, 32'h0);
        check("miss_cnt2", aw_miss_cnt, 32'd2);
        step();

        // saturation and clear priority
        force dut.u_aw.cnt_q = 32'hFFFF_FFFF;
        exp_cnt[0] = 32'hFFFF_FFFF;
        @(negedge aclk);
        #1;
        release dut.u_aw.cnt_q;
        step();
        s_aw_valid = 1; s_aw_addr = 32'h0000_0042; s_aw_user = 16'h0007;
        step();
        s_aw_valid = 0;
        @(negedge aclk);
        check("sat_cnt", aw_miss_cnt, 32'hFFFF_FFFF);
        step();
        clr_cnt = 1; s_aw_valid = 1;
        step();
        clr_cnt = 0; s_aw_valid = 0;
        @(negedge aclk);
        check("clr_prio", aw_miss_cnt, 32'h0);
        check("clr_prio_p", aw_miss_cnt_p, 32'h0);
        step();

        // reset while stalled
        m_aw_ready = 0;
        s_aw_valid = 1; s_aw_addr = 32'h0ABC_0000; s_aw_user = 16'h0002; s_aw_side = 32'h9;
        step();
        s_aw_valid = 0;
        step();
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_stall_valid", m_aw_valid, 1'b0);
        check("rst_stall_addr", m_aw_addr, 32'h0);
        repeat (2) step();
        aresetn = 1'b1;
        m_aw_ready = 1;
        step();
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cfg_wr_en  = ($urandom_range(0, 9) == 0);
            cfg_idx    = 2'($urandom_range(0, 3));
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_dsid   = 16'($urandom_range(0, 3));
            cfg_base   = $urandom;
            cfg_mask   = $urandom;
            s_aw_valid = ($urandom_range(0, 2) != 0);
            s_aw_addr  = $urandom;
            s_aw_user  = 16'($urandom_range(0, 4));
            s_aw_side  = $urandom;
            s_ar_valid = ($urandom_range(0, 2) != 0);
            s_ar_addr  = $urandom;
            s_ar_user  = 16'($urandom_range(0, 4));
            s_ar_side  = $urandom;
            m_aw_ready = ($urandom_range(0, 3) != 0);
            m_ar_ready = ($urandom_range(0, 3) != 0);
            clr_cnt    = ($urandom_range(0, 49) == 0);
            step();
        end

        idle();
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mig_addr_remap_slice.md
Name: mig_addr_remap_slice

Overview:
Parametrised successor to the memory-controller control-plane address translation. It holds a C_NUM_ENTRIES-deep, fully associative DSID→(base, mask) table and applies the remap to the AW and AR channels through registered one-deep slices, replacing the combinational path. It adds per-entry valid bits, a selectable miss policy and saturating per-channel miss counters. It sits between the tagged AXI master side and the MIG; the W/R/B channels bypass it.

Parameters:
C_DSID_WIDTH, 16, width of the DSID tag carried on awuser/aruser
C_ADDR_WIDTH, 32, AXI address width
C_NUM_ENTRIES, 4, table depth (1..16)
C_IDX_WIDTH, 2, clog2(C_NUM_ENTRIES), minimum 1
C_SIDE_WIDTH, 32, opaque AW/AR sideband (id, len, size, burst, lock, cache, prot, qos), carried unchanged
C_MISS_MODE, 0, 0 = address forced to 0 on miss; 1 = untranslated pass-through on miss

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cfg_wr_en  in  1  table write strobe
cfg_idx  in  C_IDX_WIDTH  entry index for write and readback
cfg_valid  in  1  entry valid bit to write
cfg_dsid  in  C_DSID_WIDTH  entry tag
cfg_base  in  C_ADDR_WIDTH  entry base
cfg_mask  in  C_ADDR_WIDTH  entry limit mask (bits replaced by base)
cfg_rdata  out  1+C_DSID_WIDTH+2*C_ADDR_WIDTH  {valid,dsid,mask,base} of entry cfg_idx, combinational
s_aw_valid/s_aw_ready  in/out  1  slave AW handshake
s_aw_addr  in  C_ADDR_WIDTH
s_aw_user  in  C_DSID_WIDTH
s_aw_side  in  C_SIDE_WIDTH
m_aw_valid/m_aw_ready  out/in  1  master AW handshake
m_aw_addr  out  C_ADDR_WIDTH
m_aw_user  out  C_DSID_WIDTH
m_aw_side  out  C_SIDE_WIDTH
s_ar_*, m_ar_*  as the AW group, for AR
aw_miss_cnt  out  32  saturating AW miss count
ar_miss_cnt  out  32  saturating AR miss count
clr_cnt  in  1  synchronous clear of both counters

Behaviour:
- Reset, asynchronous on aresetn low: all entry valid bits 0; dsid/base/mask 0; both slices empty (m_*_valid = 0; m_*_addr/user/side = 0); counters 0. s_*_ready = 1 one cycle after aresetn deasserts.
- A reset asserted mid-transfer discards any held beat with no output. The master side must tolerate this (system-wide reset).
- Table: a write takes effect at the clock edge. A lookup in the same cycle as a write to the matched entry uses the old contents.
- Lookup, per channel: hit = any entry with valid && dsid == s_*_user. The lowest-index hit wins.
- Translated address = (addr & ~mask) | base, bitwise, C_ADDR_WIDTH wide, no carry.
- Miss with C_MISS_MODE = 0: address 0. Miss with C_MISS_MODE = 1: addr unchanged.
- user and side are always copied unchanged.
- Slice, per channel, independent: full-throughput one-deep register.
  - s_ready = !full || m_ready.
  - On s_valid && s_ready: register the translated beat, full <= 1.
  - On m_valid && m_ready with no new accept: full <= 0.
  - Latency is 1 cycle. Back-to-back accepts are sustained at 1 beat/cycle while m_ready = 1.
  - m_valid = full. Output payload stays stable while m_valid && !m_ready (AXI rule).
- Miss counters increment by 1 on each accepted miss beat and saturate at 32'hFFFFFFFF.
  - clr_cnt has priority over an increment in the same cycle; the result is 0.
- AW and AR are fully independent. Simultaneous accepts on both channels are both processed.

Decomposition:
- Shared package: entry field offsets and widths, C_MISS_MODE encodings (MISS_ZERO = 0, MISS_PASS = 1), cfg_rdata packing order.
- One sub-module, mig_remap_chan: lookup mux, translate, slice register, miss counter. It is instantiated twice (AW, AR).
- The table registers live in the top module.

Test Plan:
- Reset, then write entry 0 = {valid 1, dsid 16'h0001, base 32'h4000_0000, mask 32'hC000_0000}. AW addr 32'h1234_5678, user 1 → after 1 cycle m_aw_addr 32'h5234_5678, aw_miss_cnt 0.
- Entries 1 and 2 both valid with dsid 16'h0002, base1 32'h1000_0000, base2 32'h2000_0000, mask 32'hF000_0000. AR addr 32'h0000_0100, user 2 → m_ar_addr 32'h1000_0100 (lowest index wins).
- User 16'h0007 (no entry): with C_MISS_MODE = 0, m_aw_addr 0; with C_MISS_MODE = 1, m_aw_addr equals s_aw_addr. aw_miss_cnt increments to 1 in both cases.
- Hold m_ar_ready = 0 for 5 cycles with beats offered → s_ar_ready = 0 after the first accept and m_ar payload stays stable. Release → 8 streamed beats exit in 8 consecutive cycles, in order, side bits intact.
- Write entry 0 with cfg_valid = 0 in the same cycle as an AW beat with user 1 → that beat is a hit (old contents). The next beat is a miss.
- Preload aw_miss_cnt to 32'hFFFFFFFF via 2^32 misses (or force in bench), then miss once → count stays at 32'hFFFFFFFF. Assert clr_cnt in the same cycle as a miss → count 0. Drop aresetn mid-stall → m_aw_valid 0 immediately.
